fc_tx_framer: RTL and testbench

Transmit-side framer for the 8G Fibre Channel link. It converts an Avalon-ST frame stream (header, payload and CRC words) into the continuous 36-bit big-endian `{datak[3:0], data[31:0]}` word stream that the transceiver TX port consumes. It adds SOF/EOF delimiters and IDLE fill, enforces the inter-frame gap, inserts R_RDY credit returns and emits primitive sequences (NOS/OLS/LR/LRR) on command from link control. It sits between the frame scheduler and the transceiver wrapper in the `tx_clk` domain. It must never leave the TX stream without a valid word.

---
 rtl/fc_tx_framer.sv | 211 +++++++++++++++++++++
 tb/tb_fc_tx_framer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_tx_framer.sv
// fc_tx_framer: turns an Avalon-ST frame stream into a continuous 36-bit
// {datak, data} transceiver word stream. It adds SOF/EOF delimiters, IDLE
// fill and R_RDY credits, enforces the inter-frame gap and sends primitive
// sequences when link control asks for them.
module fc_tx_framer #(
    parameter int MIN_FILL = 6,
    parameter int RRDY_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,
    input  logic        in_sof_type,
    input  logic        in_eof_type,
    input  logic [2:0]  link_cmd,
    input  logic        rrdy_req,
    output logic [35:0] avtx_data,
    output logic        avtx_valid,
    input  logic        avtx_ready,
    output logic        underrun,
    output logic [15:0] frame_count,
    output logic [15:0] abort_count
);

    localparam int GAP_W = (MIN_FILL < 1) ? 1 : $clog2(MIN_FILL + 1);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(MIN_FILL);
    localparam logic [RRDY_W-1:0] PEND_MAX = '1;

    localparam logic [35:0] W_IDLE = {4'b1000, 32'hBC95B5B5};
    localparam logic [35:0] W_RRDY = {4'b1000, 32'hBC954A4A};
    localparam logic [35:0] W_SOFI = {4'b1000, 32'hBCB55656};
    localparam logic [35:0] W_SOFN = {4'b1000, 32'hBCB53636};
    localparam logic [35:0] W_EOFN = {4'b1000, 32'hBC95D5D5};
    localparam logic [35:0] W_EOFT = {4'b1000, 32'hBC957575};
    localparam logic [35:0] W_EOFA = {4'b1000, 32'hBC95F5F5};
    localparam logic [35:0] W_NOS  = {4'b1000, 32'hBC55BF45};
    localparam logic [35:0] W_OLS  = {4'b1000, 32'hBC358A55};
    localparam logic [35:0] W_LR   = {4'b1000, 32'hBC49BF49};
    localparam logic [35:0] W_LRR  = {4'b1000, 32'hBC35BF49};

    typedef enum logic [1:0] {FILL, DATA, DROP, PRIM} state_t;

    state_t             state_reg;
    logic [GAP_W-1:0]   gap_reg;
    logic [RRDY_W-1:0]  pend_reg;
    logic               eof_pend_reg;   // last word accepted, EOF goes out next
    logic               eof_type_reg;
    logic [35:0]        avtx_data_reg;
    logic               avtx_valid_reg;
    logic               underrun_reg;
    logic [15:0]        frame_count_reg;
    logic [15:0]        abort_count_reg;

    logic               cmd_active;
    logic               fill_rrdy;
    logic               sof_ok;
    logic [35:0]        prim_word;
    logic [35:0]        fill_word;
    logic [RRDY_W-1:0]  pend_plus;
    logic [RRDY_W-1:0]  pend_fill;
    logic [GAP_W-1:0]   gap_inc;

    assign cmd_active = (link_cmd == 3'd0);
    assign fill_rrdy  = (pend_reg != '0);
    assign fill_word  = fill_rrdy ? W_RRDY : W_IDLE;
    assign pend_plus  = (rrdy_req && (pend_reg != PEND_MAX)) ? pend_reg + RRDY_W'(1) : pend_reg;
    // A request arriving while an R_RDY is sent cancels the decrement.
    assign pend_fill  = fill_rrdy ? (rrdy_req ? pend_reg : pend_reg - RRDY_W'(1)) : pend_plus;
    assign gap_inc    = (gap_reg >= GAP_MAX) ? GAP_MAX : gap_reg + GAP_W'(1);
    assign sof_ok     = cmd_active && (gap_reg >= GAP_MAX) && in_valid && in_startofpacket;

    // Primitive selected by link control; undefined codes fall back to NOS.
    always_comb begin
        prim_word = W_NOS;
        case (link_cmd)
            3'd2:    prim_word = W_OLS;
            3'd3:    prim_word = W_LR;
            3'd4:    prim_word = W_LRR;
            default: prim_word = W_NOS;
        endcase
    end

    // Input acceptance: frame words in DATA, draining in DROP, stray
    // non-SOP words discarded in FILL; nothing while the transceiver stalls.
    always_comb begin
        in_ready = 1'b0;
        if (avtx_ready && !reset) begin
            case (state_reg)
                FILL:    in_ready = in_valid && !in_startofpacket;
                DATA:    in_ready = !eof_pend_reg;
                DROP:    in_ready = 1'b1;
                default: in_ready = 1'b0;
            endcase
        end
    end

    // Framing FSM: picks the next TX word and updates gap, credit and
    // frame counters. Everything holds while avtx_ready is low except
    // incoming R_RDY requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= FILL;
            gap_reg         <= '0;
            pend_reg        <= '0;
            eof_pend_reg    <= 1'b0;
            eof_type_reg    <= 1'b0;
            avtx_data_reg   <= W_IDLE;
            avtx_valid_reg  <= 1'b0;
            underrun_reg    <= 1'b0;
            frame_count_reg <= '0;
            abort_count_reg <= '0;
        end else begin
            avtx_valid_reg <= 1'b1;
            underrun_reg   <= 1'b0;
            if (!avtx_ready) begin
                if (state_reg != PRIM) begin
                    pend_reg <= pend_plus;
                end
            end else begin
                unique case (state_reg)
                    FILL: begin
                        if (!cmd_active) begin
                            avtx_data_reg <= prim_word;
                            state_reg     <= PRIM;
                            pend_reg      <= '0;
                        end else if (sof_ok) begin
                            // SOP word stays on the input until DATA accepts it.
                            avtx_data_reg <= in_sof_type ? W_SOFN : W_SOFI;
                            state_reg     <= DATA;
                            pend_reg      <= pend_plus;
                        end else begin
                            avtx_data_reg <= fill_word;
                            gap_reg       <= gap_inc;
                            pend_reg      <= pend_fill;
                        end
                    end
                    DATA: begin
                        if (eof_pend_reg) begin
                            avtx_data_reg   <= eof_type_reg ? W_EOFT : W_EOFN;
                            frame_count_reg <= frame_count_reg + 16'd1;
                            gap_reg         <= '0;
                            eof_pend_reg    <= 1'b0;
                            state_reg       <= cmd_active ? FILL : PRIM;
                            pend_reg        <= cmd_active ? pend_plus : '0;
                        end else if (!cmd_active || !in_valid) begin
                            // Abort: a word taken this cycle is dropped; if it
                            // closed the frame there is nothing left to drain.
                            avtx_data_reg   <= W_EOFA;
                            underrun_reg    <= 1'b1;
                            abort_count_reg <= abort_count_reg + 16'd1;
                            gap_reg         <= '0;
                            if (!cmd_active && in_valid && in_endofpacket) begin
                                state_reg <= PRIM;
                                pend_reg  <= '0;
                            end else begin
                                state_reg <= DROP;
                                pend_reg  <= pend_plus;
                            end
                        end else begin
                            avtx_data_reg <= {4'b0000, in_data};
                            pend_reg      <= pend_plus;
                            if (in_endofpacket) begin
                                eof_pend_reg <= 1'b1;
                                eof_type_reg <= in_eof_type;
                            end
                        end
                    end
                    DROP: begin
                        // While link control wants a primitive it goes out
                        // even before the aborted frame has drained.
                        if (!cmd_active) begin
                            avtx_data_reg <= prim_word;
                            pend_reg      <= pend_plus;
                        end else begin
                            avtx_data_reg <= fill_word;
                            gap_reg       <= gap_inc;
                            pend_reg      <= pend_fill;
                        end
                        if (in_valid && in_endofpacket) begin
                            state_reg <= cmd_active ? FILL : PRIM;
                            if (!cmd_active) begin
                                pend_reg <= '0;
                            end
                        end
                    end
                    PRIM: begin
                        pend_reg <= '0;
                        if (cmd_active) begin
                            // Leaving PRIM: this IDLE is the first fill word.
                            avtx_data_reg <= W_IDLE;
                            gap_reg       <= GAP_W'(1);
                            state_reg     <= FILL;
                        end else begin
                            avtx_data_reg <= prim_word;
                        end
                    end
                endcase
            end
        end
    end

    assign avtx_data   = avtx_data_reg;
    assign avtx_valid  = avtx_valid_reg;
    assign underrun    = underrun_reg;
    assign frame_count = frame_count_reg;
    assign abort_count = abort_count_reg;

endmodule

// File: tb/tb_fc_tx_framer.sv
// tb_fc_tx_framer: scenario tasks drive random frames into fc_tx_framer and
// compare the transferred TX word stream with a stream built from the
// framing rules (fill gap, delimiters, credits, primitives).
module tb_fc_tx_framer;

    localparam logic [35:0] K_IDLE = {4'b1000, 32'hBC95B5B5};
    localparam logic [35:0] K_RRDY = {4'b1000, 32'hBC954A4A};
    localparam logic [35:0] K_SOFI = {4'b1000, 32'hBCB55656};
    localparam logic [35:0] K_SOFN = {4'b1000, 32'hBCB53636};
    localparam logic [35:0] K_EOFN = {4'b1000, 32'hBC95D5D5};
    localparam logic [35:0] K_EOFT = {4'b1000, 32'hBC957575};
    localparam logic [35:0] K_EOFA = {4'b1000, 32'hBC95F5F5};
    localparam logic [35:0] K_OLS  = {4'b1000, 32'hBC358A55};
    localparam logic [35:0] K_LR   = {4'b1000, 32'hBC49BF49};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] in_data;
    logic        in_valid, in_ready, in_startofpacket, in_endofpacket;
    logic        in_sof_type, in_eof_type;
    logic [2:0]  link_cmd;
    logic        rrdy_req;
    logic [35:0] avtx_data;
    logic        avtx_valid, avtx_ready, underrun;
    logic [15:0] frame_count, abort_count;

    fc_tx_framer #(.MIN_FILL(6), .RRDY_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
        .in_sof_type(in_sof_type), .in_eof_type(in_eof_type),
        .link_cmd(link_cmd), .rrdy_req(rrdy_req),
        .avtx_data(avtx_data), .avtx_valid(avtx_valid), .avtx_ready(avtx_ready),
        .underrun(underrun), .frame_count(frame_count), .abort_count(abort_count)
    );

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic        st;
        logic        et;
    } src_t;

    src_t        src_q[$];
    logic [35:0] cap_q[$];
    logic [35:0] exp_q[$];
    logic [35:0] frm_q[$];
    int n_vec = 0;
    int n_err = 0;
    int pop_cnt = 0;
    int drop_at = -1;
    bit dropped = 1'b0;
    int under_cnt = 0;

    task automatic drive();
        if (src_q.size() > 0 && !(pop_cnt == drop_at && !dropped)) begin
            in_valid         = 1'b1;
            in_data          = src_q[0].data;
            in_startofpacket = src_q[0].sop;
            in_endofpacket   = src_q[0].eop;
            in_sof_type      = src_q[0].st;
            in_eof_type      = src_q[0].et;
        end else begin
            in_valid         = 1'b0;
            in_data          = '0;
            in_startofpacket = 1'b0;
            in_endofpacket   = 1'b0;
            in_sof_type      = 1'b0;
            in_eof_type      = 1'b0;
        end
    endtask

    // One clock: drive source, sample handshakes before the edge, advance.
    task automatic step();
        logic hs;
        logic drop_now;
        drive();
        drop_now = (pop_cnt == drop_at) && !dropped && (src_q.size() > 0);
        #1;
        hs = in_valid && in_ready;
        if (avtx_valid && avtx_ready) cap_q.push_back(avtx_data);
        if (underrun) under_cnt++;
        @(posedge clk);
        #1;
        if (hs) begin
            src_q.delete(0);
            pop_cnt++;
        end
        if (drop_now) dropped = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        link_cmd = 3'd0;
        rrdy_req = 1'b0;
        avtx_ready = 1'b1;
        src_q.delete();
        frm_q.delete();
        exp_q.delete();
        pop_cnt = 0;
        drop_at = -1;
        dropped = 1'b0;
        step();
        step();
        reset = 1'b0;
        cap_q.delete();
        under_cnt = 0;
    endtask

    task automatic push_frame(input int len, input logic st, input logic et);
        for (int i = 0; i < len; i++) begin
            src_t w;
            w.data = $urandom;
            w.sop  = (i == 0);
            w.eop  = (i == len - 1);
            w.st   = st;
            w.et   = et;
            src_q.push_back(w);
            frm_q.push_back({4'b0000, w.data});
        end
    endtask

    // Expected wire image of one complete frame preceded by gap fill words.
    task automatic exp_frame(input int gap, input logic st, input logic et,
                             input int first, input int len);
        repeat (gap) exp_q.push_back(K_IDLE);
        exp_q.push_back(st ? K_SOFN : K_SOFI);
        for (int i = first; i < first + len; i++) exp_q.push_back(frm_q[i]);
        exp_q.push_back(et ? K_EOFT : K_EOFN);
    endtask

    task automatic test_reset();
        int guard;
        do_reset();
        n_vec++;
        if (avtx_valid !== 1'b0 || avtx_data !== K_IDLE) begin
            n_err++;
            $display("FAIL reset_out: got valid=%b data=%h, expected valid=0 data=%h", avtx_valid, avtx_data, K_IDLE);
        end
        n_vec++;
        if (frame_count !== 16'd0 || abort_count !== 16'd0 || underrun !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cnt: got frames=%0d aborts=%0d underrun=%b, expected 0 0 0", frame_count, abort_count, underrun);
        end
        // Reset in the middle of a frame.
        push_frame(8, 1'b0, 1'b0);
        guard = 0;
        while (pop_cnt < 3 && guard < 40) begin step(); guard++; end
        reset = 1'b1;
        step();
        n_vec++;
        if (avtx_valid !== 1'b0 || avtx_data !== K_IDLE || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_midframe: got valid=%b data=%h in_ready=%b, expected 0 %h 0", avtx_valid, avtx_data, in_ready, K_IDLE);
        end
        reset = 1'b0;
        src_q.delete();
        cap_q.delete();
        repeat (4) step();
        n_vec++;
        if (cap_q.size() < 1 || cap_q[0] !== K_IDLE || frame_count !== 16'd0 || abort_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_first_word: got %h (n=%0d) frames=%0d aborts=%0d, expected %h 0 0",
                     (cap_q.size() > 0) ? cap_q[0] : 36'h0, cap_q.size(), frame_count, abort_count, K_IDLE);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        push_frame(8, 1'b0, 1'b1);
        exp_frame(6, 1'b0, 1'b1, 0, 8);
        exp_q.push_back(K_IDLE);
        repeat (30) step();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL single_frame word %0d: got %h, expected %h", i, (i < cap_q.size()) ? cap_q[i] : 36'h0, exp_q[i]);
            end
        end
        n_vec++;
        if (frame_count !== 16'd1) begin
            n_err++;
            $display("FAIL single_frame count: got %0d, expected 1", frame_count);
        end
    endtask

    task automatic test_back_to_back();
        int lens[4];
        logic sts[4];
        logic ets[4];
        int first;
        int total;
        do_reset();
        first = 0;
        total = 0;
        for (int f = 0; f < 4; f++) begin
            lens[f] = $urandom_range(1, 10);
            sts[f]  = 1'($urandom_range(0, 1));
            ets[f]  = 1'($urandom_range(0, 1));
            push_frame(lens[f], sts[f], ets[f]);
            total += lens[f] + 8;
        end
        for (int f = 0; f < 4; f++) begin
            exp_frame(6, sts[f], ets[f], first, lens[f]);
            first += lens[f];
        end
        exp_q.push_back(K_IDLE);
        repeat (total + 12) step();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL back_to_back word %0d: got %h, expected %h", i, (i < cap_q.size()) ? cap_q[i] : 36'h0, exp_q[i]);
            end
        end
        n_vec++;
        if (frame_count !== 16'd4) begin
            n_err++;
            $display("FAIL back_to_back count: got %0d, expected 4", frame_count);
        end
    endtask

    task automatic test_gap_saturation();
        logic st;
        logic et;
        do_reset();
        st = 1'($urandom_range(0, 1));
        et = 1'($urandom_range(0, 1));
        repeat (20) step();
        push_frame(3, st, et);
        exp_frame(20, st, et, 0, 3);
        exp_q.push_back(K_IDLE);
        repeat (12) step();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL gap_saturation word %0d: got %h, expected %h", i, (i < cap_q.size()) ? cap_q[i] : 36'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_underrun();
        do_reset();
        push_frame(5, 1'b0, 1'b0);
        push_frame(3, 1'b1, 1'b1);
        drop_at = 2;
        repeat (6) exp_q.push_back(K_IDLE);
        exp_q.push_back(K_SOFI);
        exp_q.push_back(frm_q[0]);
        exp_q.push_back(frm_q[1]);
        exp_q.push_back(K_EOFA);
        exp_frame(6, 1'b1, 1'b1, 5, 3);
        exp_q.push_back(K_IDLE);
        repeat (40) step();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL underrun word %0d: got %h, expected %h", i, (i < cap_q.size()) ? cap_q[i] : 36'h0, exp_q[i]);
            end
        end
        n_vec++;
        if (under_cnt !== 1 || abort_count !== 16'd1 || frame_count !== 16'd1) begin
            n_err++;
            $display("FAIL underrun counters: got pulses=%0d aborts=%0d frames=%0d, expected 1 1 1", under_cnt, abort_count, frame_count);
        end
    endtask

    task automatic test_rrdy_in_frame();
        do_reset();
        push_frame(6, 1'b1, 1'b0);
        push_frame(4, 1'b0, 1'b1);
        for (int s = 0; s < 50; s++) begin
            rrdy_req = (pop_cnt >= 1 && pop_cnt <= 3);
            step();
        end
        rrdy_req = 1'b0;
        exp_frame(6, 1'b1, 1'b0, 0, 6);
        repeat (3) exp_q.push_back(K_RRDY);
        exp_frame(3, 1'b0, 1'b1, 6, 4);
        exp_q.push_back(K_IDLE);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rrdy_in_frame word %0d: got %h, expected %h", i, (i < cap_q.size()) ? cap_q[i] : 36'h0, exp_q[i]);
            end
        end
    endtask

    // Random request pulses while idle: each R_RDY leaves at the first
    // cycle after its request that is not already taken by an earlier one.
    task automatic test_rrdy_coincide();
        int req_at[$];
        bit is_r[80];
        int last;
        int t;
        do_reset();
        repeat (8) step();
        cap_q.delete();
        for (int s = 0; s < 80; s++) begin
            rrdy_req = (s < 40) && ((s < 2) || ($urandom_range(0, 2) == 0));
            if (rrdy_req) req_at.push_back(s);
            step();
        end
        rrdy_req = 1'b0;
        for (int s = 0; s < 80; s++) is_r[s] = 1'b0;
        last = -1;
        foreach (req_at[k]) begin
            t = (req_at[k] + 1 > last + 1) ? req_at[k] + 1 : last + 1;
            last = t;
            if (t < 80) is_r[t] = 1'b1;
        end
        exp_q.push_back(K_IDLE);
        for (int i = 1; i < 80; i++) exp_q.push_back(is_r[i-1] ? K_RRDY : K_IDLE);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rrdy_coincide word %0d: got %h, expected %h", i, (i < cap_q.size()) ? cap_q[i] : 36'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_link_cmd();
        int guard;
        logic st;
        logic et;
        do_reset();
        st = 1'($urandom_range(0, 1));
        et = 1'($urandom_range(0, 1));
        push_frame(6, 1'b0, 1'b0);
        guard = 0;
        while (pop_cnt < 3 && guard < 40) begin step(); guard++; end
        n_vec++;
        if (pop_cnt < 3) begin
            n_err++;
            $display("FAIL link_cmd start: got %0d words accepted, expected 3", pop_cnt);
        end
        link_cmd = 3'd2;
        step();
        repeat (9) step();
        link_cmd = 3'd3;
        repeat (5) step();
        link_cmd = 3'd0;
        push_frame(2, st, et);
        repeat (20) step();
        repeat (6) exp_q.push_back(K_IDLE);
        exp_q.push_back(K_SOFI);
        for (int i = 0; i < 3; i++) exp_q.push_back(frm_q[i]);
        exp_q.push_back(K_EOFA);
        repeat (9) exp_q.push_back(K_OLS);
        repeat (5) exp_q.push_back(K_LR);
        exp_frame(6, st, et, 6, 2);
        exp_q.push_back(K_IDLE);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL link_cmd word %0d: got %h, expected %h", i, (i < cap_q.size()) ? cap_q[i] : 36'h0, exp_q[i]);
            end
        end
        n_vec++;
        if (under_cnt !== 1 || abort_count !== 16'd1 || frame_count !== 16'd1) begin
            n_err++;
            $display("FAIL link_cmd counters: got pulses=%0d aborts=%0d frames=%0d, expected 1 1 1", under_cnt, abort_count, frame_count);
        end
    endtask

    task automatic test_backpressure();
        int guard;
        logic [35:0] held;
        do_reset();
        push_frame(8, 1'b1, 1'b1);
        guard = 0;
        while (pop_cnt < 3 && guard < 40) begin step(); guard++; end
        held = avtx_data;
        avtx_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            n_vec++;
            if (avtx_data !== held || in_ready !== 1'b0 || pop_cnt !== 3) begin
                n_err++;
                $display("FAIL stall cycle %0d: got data=%h in_ready=%b accepted=%0d, expected data=%h in_ready=0 accepted=3",
                         c, avtx_data, in_ready, pop_cnt, held);
            end
        end
        avtx_ready = 1'b1;
        repeat (20) step();
        exp_frame(6, 1'b1, 1'b1, 0, 8);
        exp_q.push_back(K_IDLE);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL stall_frame word %0d: got %h, expected %h", i, (i < cap_q.size()) ? cap_q[i] : 36'h0, exp_q[i]);
            end
        end
        n_vec++;
        if (under_cnt !== 0 || abort_count !== 16'd0 || frame_count !== 16'd1) begin
            n_err++;
            $display("FAIL stall counters: got pulses=%0d aborts=%0d frames=%0d, expected 0 0 1", under_cnt, abort_count, frame_count);
        end
    endtask

    initial begin
        reset = 1'b1;
        link_cmd = 3'd0;
        rrdy_req = 1'b0;
        avtx_ready = 1'b1;
        drive();
        @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gap_saturation();
        test_underrun();
        test_rrdy_in_frame();
        test_rrdy_coincide();
        test_link_cmd();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
